// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and control-word constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  // Controller FSM states; 2'b11 is unused and treated as a fault.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // One bit per pipeline-register control line, MSB first.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_write;
  } ctrl_t;

  // Normal advance: every register loads, nothing squashed.
  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                 id_ex_bubble: 1'b0, ex_mem_write: 1'b1, mem_wb_write: 1'b1};
  // Full freeze: nothing moves, nothing is squashed.
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b0, ex_mem_write: 1'b0, mem_wb_write: 1'b0};
  // Load-use stall: hold PC and IF/ID, inject a bubble into ID/EX.
  localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                   id_ex_bubble: 1'b1, ex_mem_write: 1'b1, mem_wb_write: 1'b1};
  // Branch redirect: load new PC, squash IF/ID and ID/EX.
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                   id_ex_bubble: 1'b1, ex_mem_write: 1'b1, mem_wb_write: 1'b1};
  // Halt request: only the retiring WB instruction commits.
  localparam ctrl_t CTRL_HALT = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                  id_ex_bubble: 1'b0, ex_mem_write: 1'b0, mem_wb_write: 1'b1};
  // While reset is asserted the pipe is filled with NOPs.
  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                   id_ex_bubble: 1'b1, ex_mem_write: 1'b0, mem_wb_write: 1'b0};

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the controller's performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = &r_count;
  assign count    = r_count;

  // Count up on each inc pulse, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline controller: write enables, flushes and bubbles for the
// 5-stage core, with a memory-freeze/halt FSM, freeze watchdog and counters.
// MEM_TIMEOUT is expected to be at least 2: the first busy cycle in RUN
// already counts as freeze cycle 1.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 7,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_freeze
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_nxt;
  logic [TO_W-1:0] w_to_inc;
  logic            w_to_fault;
  logic            r_halted;
  logic            r_mem_timeout;
  logic            w_frozen;
  ctrl_t           w_ctrl;
  logic            w_inc_stall;
  logic            w_inc_flush;
  logic            w_inc_freeze;

  // A FREEZE cycle with memory still busy keeps everything held; once busy
  // drops, the same cycle is evaluated exactly like RUN.
  assign w_frozen = (r_state == ST_FREEZE) && dmem_busy;
  assign w_to_inc = r_to_cnt + TO_W'(1);

  // State, watchdog count and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_to_cnt      <= '0;
      r_halted      <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_to_cnt      <= w_to_nxt;
      r_halted      <= (w_state_nxt == ST_HALTED);
      r_mem_timeout <= r_mem_timeout | w_to_fault;
    end
  end

  // Next-state and watchdog-count logic.
  always_comb begin
    w_state_nxt = r_state;
    w_to_nxt    = r_to_cnt;
    w_to_fault  = 1'b0;
    case (r_state)
      ST_RUN, ST_FREEZE: begin
        if (w_frozen) begin
          w_to_nxt = w_to_inc;
          if (w_to_inc == TO_LIMIT) begin
            w_state_nxt = ST_HALTED;
            w_to_fault  = 1'b1;
          end else begin
            w_state_nxt = ST_FREEZE;
          end
        end else if (halt_req) begin
          w_state_nxt = ST_HALTED;
          w_to_nxt    = '0;
        end else if (dmem_busy) begin
          w_state_nxt = ST_FREEZE;
          w_to_nxt    = TO_W'(1);
        end else begin
          w_state_nxt = ST_RUN;
          w_to_nxt    = '0;
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        // Unreachable encoding: park the pipe until reset.
        w_state_nxt = ST_HALTED;
        w_to_nxt    = '0;
      end
    endcase
  end

  // Control word and counter increments; at most one counter steps per cycle.
  always_comb begin
    w_ctrl       = CTRL_FREEZE;
    w_inc_stall  = 1'b0;
    w_inc_flush  = 1'b0;
    w_inc_freeze = 1'b0;
    if (!rst_n) begin
      w_ctrl = CTRL_RESET;
    end else begin
      case (r_state)
        ST_RUN, ST_FREEZE: begin
          if (w_frozen) begin
            w_ctrl       = CTRL_FREEZE;
            w_inc_freeze = 1'b1;
          end else if (halt_req) begin
            w_ctrl = CTRL_HALT;
          end else if (dmem_busy) begin
            // Branch/stall stay latched in the frozen stages and reappear later.
            w_ctrl       = CTRL_FREEZE;
            w_inc_freeze = 1'b1;
          end else if (branch_taken) begin
            // A coincident stall is moot: the ID instruction is squashed.
            w_ctrl      = CTRL_FLUSH;
            w_inc_flush = 1'b1;
          end else if (stall) begin
            w_ctrl      = CTRL_STALL;
            w_inc_stall = 1'b1;
          end else begin
            w_ctrl = CTRL_RUN;
          end
        end
        ST_HALTED: begin
          w_ctrl = CTRL_FREEZE;
        end
        default: begin
          w_ctrl = CTRL_FREEZE;
        end
      endcase
    end
  end

  assign pc_write     = w_ctrl.pc_write;
  assign if_id_write  = w_ctrl.if_id_write;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_bubble = w_ctrl.id_ex_bubble;
  assign ex_mem_write = w_ctrl.ex_mem_write;
  assign mem_wb_write = w_ctrl.mem_wb_write;
  assign halted       = r_halted;
  assign mem_timeout  = r_mem_timeout;

  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc_stall),
    .count (cnt_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc_flush),
    .count (cnt_flush)
  );

  sat_counter #(.W(CNT_W)) u_cnt_freeze (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc_freeze),
    .count (cnt_freeze)
  );

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central pipeline-control block. It consumes the load-use `stall` produced by hazard detection, plus branch-taken, data-memory-busy and halt requests.
- Drives every pipeline write-enable, flush and bubble in the 5-stage RISC-V core.
- Owns a small FSM for multi-cycle memory freezes and halt, with a watchdog timeout and saturating performance counters.
- Sits between hazard detection/EX/MEM/WB sources and the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- MEM_TIMEOUT, 64, maximum consecutive freeze cycles before a timeout fault.
- TO_W, 7, width of the timeout counter; must hold MEM_TIMEOUT.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- stall  in  1  load-use hazard request from hazard detection.
- branch_taken  in  1  EX-stage branch/jump redirect.
- dmem_busy  in  1  data memory not ready; MEM access incomplete.
- halt_req  in  1  ecall/ebreak retiring in WB.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID load NOP.
- id_ex_bubble  out  1  ID/EX load NOP (control bits zeroed).
- ex_mem_write  out  1  EX/MEM enable.
- mem_wb_write  out  1  MEM/WB enable.
- halted  out  1  core halted (sticky).
- mem_timeout  out  1  sticky fault: freeze exceeded MEM_TIMEOUT.
- cnt_stall  out  CNT_W  load-use stall cycles.
- cnt_flush  out  CNT_W  branch flush events.
- cnt_freeze  out  CNT_W  memory freeze cycles.

Behaviour:
- FSM states: RUN, FREEZE, HALTED. Reset state is RUN.
- Reset (rst_n=0, asynchronous):
  - State goes to RUN; timeout counter, halted, mem_timeout and all counters go to 0.
  - Control outputs are forced while rst_n=0: pc_write=0, if_id_write=0, ex_mem_write=0, mem_wb_write=0, if_id_flush=1, id_ex_bubble=1. This fills the pipe with NOPs.
- Control outputs are combinational from the current state and inputs. Zero-cycle latency: a request affects the same clock edge.
- RUN priority, highest first:
  1. halt_req:
     - mem_wb_write=1, so the retiring instruction commits this edge.
     - All other enables 0; if_id_flush=0; id_ex_bubble=0.
     - Next state HALTED.
  2. dmem_busy:
     - Full freeze: all write enables 0; no flush and no bubble.
     - Next state FREEZE; timeout counter loads 1.
     - cnt_freeze increments.
     - A coincident branch_taken or stall is ignored this cycle. It is re-evaluated when the freeze ends, because the frozen EX/ID contents still present it.
  3. branch_taken:
     - pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_write=1, mem_wb_write=1.
     - cnt_flush increments.
     - A coincident stall is discarded, since the ID instruction is squashed.
  4. stall:
     - pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1, mem_wb_write=1.
     - cnt_stall increments.
  5. None of the above: all enables 1; if_id_flush=0; id_ex_bubble=0.
- FREEZE:
  - While dmem_busy=1:
    - Outputs remain a full freeze and cnt_freeze increments.
    - The timeout counter increments.
    - When the counter equals MEM_TIMEOUT with dmem_busy still 1, set mem_timeout=1 and go to HALTED.
  - When dmem_busy=0: return to RUN with the timeout counter cleared. Outputs that cycle follow the RUN priority rules (same cycle, no extra delay).
  - halt_req is not sampled in FREEZE, because WB is frozen.
- HALTED:
  - All write enables 0; halted=1; flush=0; bubble=0.
  - No further counter updates.
  - Exit only via reset.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Exactly one counter increments per cycle at most.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - State enum (RUN, FREEZE, HALTED).
  - Packed struct ctrl_t {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_write}.
  - Constants CTRL_RUN, CTRL_FREEZE, CTRL_STALL, CTRL_FLUSH, CTRL_HALT, CTRL_RESET.
- One sub-module, sat_counter (param W, inputs inc, rst_n), instantiated three times.

Test Plan:
- Reset with rst_n=0 for 3 cycles, then release → during reset pc_write=0, if_id_flush=1, id_ex_bubble=1. After release with no requests, all enables=1 and counters=0.
- stall=1 for 1 cycle → that cycle pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1; cnt_stall=1 next cycle.
- stall=1 and branch_taken=1 together → flush pattern (if_id_flush=1, id_ex_bubble=1, pc_write=1); cnt_flush=1, cnt_stall=0.
- dmem_busy=1 for 5 cycles with branch_taken=1 throughout → 5 full-freeze cycles, cnt_freeze=5, cnt_flush=0. On the 6th cycle (busy=0) the flush pattern applies and cnt_flush=1.
- MEM_TIMEOUT=4 with dmem_busy held high → mem_timeout=1 and halted=1 after the 4th freeze cycle. Enables stay 0 after busy drops; only rst_n clears the fault.
- halt_req=1 in RUN → mem_wb_write=1 that cycle, other enables 0. halted=1 from the next cycle; later stall/branch pulses leave counters unchanged.
- Separate run with CNT_W=4 and 20 stall cycles → cnt_stall holds at 15.
